// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared uOP types and decode helpers for the CPU pipeline
//
// Purpose: functional-unit and operation enums, the uOP_t pipeline record,
// register-name constants and small op-class decode helpers.
// Ports: none (package).

package mem_stage_pkg;

   typedef enum logic [2:0] {
      GALU, BRU, CSR, FPU, GLSU, GMUL, VPU
   } fu_e;

   typedef enum logic [4:0] {
      _NOP,
      _LB, _LH, _LW, _LBU, _LHU, _FLW,
      _SB, _SH, _SW, _FSW,
      _CSRRW, _CSRRS, _CSRRC, _CSRRWI, _CSRRSI, _CSRRCI
   } op_e;

   localparam logic [4:0] X0 = 5'd0;

   typedef struct packed {
      logic        valid;
      op_e         op;
      fu_e         fu;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [31:0] result;
      logic [31:0] pc;
   } uOP_t;

   function automatic logic is_load(input op_e op);
      return op inside {_LB, _LH, _LW, _LBU, _LHU, _FLW};
   endfunction

   // Set/clear CSR variants skip the CSR write when the source is x0 / zimm==0.
   function automatic logic is_csr_set_clr(input op_e op);
      return op inside {_CSRRS, _CSRRC, _CSRRSI, _CSRRCI};
   endfunction

endpackage

// File: rtl/mem_stage_load_extract.sv
// rtl/mem_stage_load_extract.sv - byte/halfword/word extraction and extension of a D$ word
//
// Purpose: shift the aligned D$ word by the bit offset computed in EXE and
// sign/zero-extend according to the load op. Purely combinational.
// Ports:
//   op     in  op_e   load operation
//   sh     in  5      bit offset of the addressed byte within the word
//   word   in  32     aligned D$ word
//   data   out 32     extended writeback value

module mem_stage_load_extract
   import mem_stage_pkg::*;
(
   input  op_e         op,
   input  logic [4:0]  sh,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [31:0] w;

   always_comb begin
      w = word >> sh;
      case (op)
         _LB:     data = {{24{w[7]}}, w[7:0]};
         _LBU:    data = {24'd0, w[7:0]};
         _LH:     data = {{16{w[15]}}, w[15:0]};
         _LHU:    data = {16'd0, w[15:0]};
         default: data = w;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - CPU memory stage: D$ completion, CSR RMW, MEM/WB register
//
// Purpose: finishes D$ loads (extract/extend), performs CSR read-modify-write,
// selects the writeback value and holds the MEM/WB register. Stalls the pipe
// while a D$ access is outstanding.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   stall_i                      external pipeline stall (hazard unit)
//   mem_uOP_i                    EXE/MEM uOP
//   mem_mul_result_i             multiplier result
//   mem_csr_operand_i            rs1 value or zimm
//   dcache_core_wait_i           D$ response not yet available
//   dcache_core_out_i            D$ read word
//   csr_addr_o/csr_rdata_i       CSR read port
//   csr_we_o/csr_wdata_o         CSR write port
//   mem_stall_o                  stall request generated here
//   wb_uOP_o, wb_data_o          MEM/WB register and forwarding value

module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int CSR_ADDR_W = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stall_i,
   input  uOP_t                  mem_uOP_i,
   input  logic [31:0]           mem_mul_result_i,
   input  logic [31:0]           mem_csr_operand_i,
   input  logic                  dcache_core_wait_i,
   input  logic [31:0]           dcache_core_out_i,
   output logic [CSR_ADDR_W-1:0] csr_addr_o,
   input  logic [31:0]           csr_rdata_i,
   output logic                  csr_we_o,
   output logic [31:0]           csr_wdata_o,
   output logic                  mem_stall_o,
   output uOP_t                  wb_uOP_o,
   output logic [31:0]           wb_data_o
);

   typedef enum logic {RUN, WAIT} mem_state_e;

   mem_state_e  state_q, state_n;
   logic [31:0] buf_q;
   logic        buf_v_q;
   logic        is_lsu, is_ld, advance;
   logic [31:0] ld_word, ld_data, data_n;
   logic        valid_n;
   uOP_t        wb_q;

   assign is_lsu  = (mem_uOP_i.fu == GLSU);
   assign is_ld   = is_lsu && is_load(mem_uOP_i.op);
   assign advance = !stall_i && !mem_stall_o;

   // Once the load word is buffered the D$ is no longer waited on.
   always_comb begin
      state_n     = state_q;
      mem_stall_o = 1'b0;
      case (state_q)
         RUN: begin
            if (is_lsu && dcache_core_wait_i && !buf_v_q) begin
               state_n     = WAIT;
               mem_stall_o = 1'b1;
            end
         end
         WAIT: begin
            if (dcache_core_wait_i) mem_stall_o = 1'b1;
            else                    state_n     = RUN;
         end
         default: state_n = RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= RUN;
      else       state_q <= state_n;
   end

   // Capture load data that returns while the pipe is held externally, since
   // the D$ output is not guaranteed to stay stable afterwards.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         buf_v_q <= 1'b0;
         buf_q   <= 32'd0;
      end else if (advance) begin
         buf_v_q <= 1'b0;
      end else if (is_ld && !dcache_core_wait_i && stall_i && !buf_v_q) begin
         buf_v_q <= 1'b1;
         buf_q   <= dcache_core_out_i;
      end
   end

   assign ld_word = buf_v_q ? buf_q : dcache_core_out_i;

   mem_stage_load_extract u_load_extract (
      .op   (mem_uOP_i.op),
      .sh   (mem_uOP_i.result[4:0]),
      .word (ld_word),
      .data (ld_data)
   );

   assign csr_addr_o = mem_uOP_i.result[CSR_ADDR_W-1:0];

   always_comb begin
      csr_wdata_o = 32'd0;
      if (mem_uOP_i.fu == CSR) begin
         case (mem_uOP_i.op)
            _CSRRW, _CSRRWI: csr_wdata_o = mem_csr_operand_i;
            _CSRRS, _CSRRSI: csr_wdata_o = csr_rdata_i | mem_csr_operand_i;
            _CSRRC, _CSRRCI: csr_wdata_o = csr_rdata_i & ~mem_csr_operand_i;
            default:         csr_wdata_o = 32'd0;
         endcase
      end
   end

   assign csr_we_o = (mem_uOP_i.fu == CSR) && !stall_i && !mem_stall_o &&
                     !(is_csr_set_clr(mem_uOP_i.op) && (mem_uOP_i.rs1 == X0));

   always_comb begin
      data_n  = mem_uOP_i.result;
      valid_n = mem_uOP_i.valid;
      case (mem_uOP_i.fu)
         GMUL: begin data_n = mem_mul_result_i; valid_n = 1'b1; end
         CSR:  begin data_n = csr_rdata_i;      valid_n = 1'b1; end
         GLSU: begin
            if (is_load(mem_uOP_i.op)) begin
               data_n  = ld_data;
               valid_n = 1'b1;
            end else begin
               valid_n = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wb_q <= uOP_t'(0);
      end else if (stall_i) begin
         wb_q <= wb_q;
      end else if (mem_stall_o) begin
         wb_q <= uOP_t'(0);
      end else begin
         wb_q        <= mem_uOP_i;
         wb_q.result <= data_n;
         wb_q.valid  <= valid_n;
      end
   end

   assign wb_uOP_o  = wb_q;
   assign wb_data_o = wb_q.result;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage

module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   uOP_t        uop;
   logic [31:0] mul, opnd, dword, rdata;
   logic        dwait;
   logic [11:0] csr_addr;
   logic        csr_we;
   logic [31:0] csr_wdata;
   logic        mstall;
   uOP_t        wb_uop;
   logic [31:0] wb_data;

   always #5 clk = ~clk;

   mem_stage #(.CSR_ADDR_W(12)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .stall_i            (stall),
      .mem_uOP_i          (uop),
      .mem_mul_result_i   (mul),
      .mem_csr_operand_i  (opnd),
      .dcache_core_wait_i (dwait),
      .dcache_core_out_i  (dword),
      .csr_addr_o         (csr_addr),
      .csr_rdata_i        (rdata),
      .csr_we_o           (csr_we),
      .csr_wdata_o        (csr_wdata),
      .mem_stall_o        (mstall),
      .wb_uOP_o           (wb_uop),
      .wb_data_o          (wb_data)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] data;
      logic        valid;
      logic [4:0]  rd;
   } sb_t;

   sb_t sbq[$];

   typedef struct {
      uOP_t        u;
      logic [31:0] mul, opnd, rdata, dword;
      logic [31:0] exp_data;
      logic        exp_valid;
      logic        exp_we;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vt[$];

   function automatic uOP_t mk(input logic v, input op_e op, input fu_e fu,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [31:0] res);
      uOP_t u;
      u        = '0;
      u.valid  = v;
      u.op     = op;
      u.fu     = fu;
      u.rd     = rd;
      u.rs1    = rs1;
      u.result = res;
      u.pc     = 32'h0000_1000;
      return u;
   endfunction

   task automatic add(input uOP_t u, input logic [31:0] m, input logic [31:0] o,
                      input logic [31:0] rd_, input logic [31:0] dw,
                      input logic [31:0] ed, input logic ev, input logic ewe,
                      input logic [31:0] ewd);
      vec_t v;
      v.u = u; v.mul = m; v.opnd = o; v.rdata = rd_; v.dword = dw;
      v.exp_data = ed; v.exp_valid = ev; v.exp_we = ewe; v.exp_wdata = ewd;
      vt.push_back(v);
   endtask

   task automatic drive(input uOP_t u, input logic [31:0] m, input logic [31:0] o,
                        input logic [31:0] rd_, input logic [31:0] dw,
                        input logic w, input logic s);
      @(negedge clk);
      uop = u; mul = m; opnd = o; rdata = rd_; dword = dw; dwait = w; stall = s;
   endtask

   task automatic expect_wb(input logic [31:0] d, input logic v, input logic [4:0] rd);
      sb_t e;
      e.data = d; e.valid = v; e.rd = rd;
      sbq.push_back(e);
   endtask

   // Advance one edge; if the scoreboard holds an expectation, it is due now.
   task automatic tick();
      sb_t e;
      @(posedge clk);
      #1;
      if (sbq.size() != 0) begin
         e = sbq.pop_front();
         chk("wb_data",   wb_data,          e.data);
         chk("wb_result", wb_uop.result,    e.data);
         chk("wb_valid",  32'(wb_uop.valid), 32'(e.valid));
         chk("wb_rd",     32'(wb_uop.rd),    32'(e.rd));
      end
   endtask

   uOP_t zu;
   int   stalls;
   logic [31:0] held;

   initial begin
      zu = '0;
      rst = 1'b1; stall = 1'b0; uop = zu; mul = 0; opnd = 0; dword = 0; dwait = 0; rdata = 0;

      // Reset state
      @(negedge clk); #1;
      chk("rst_csr_we",    32'(csr_we),   0);
      chk("rst_mem_stall", 32'(mstall),   0);
      chk("rst_csr_addr",  32'(csr_addr), 0);
      chk("rst_csr_wdata", csr_wdata,     0);
      @(posedge clk); #1;
      chk("rst_wb_uop",  32'(wb_uop != zu), 0);
      chk("rst_wb_data", wb_data, 0);
      @(negedge clk); rst = 1'b0;

      // Single-cycle vectors: uop, mul, opnd, csr_rdata, dword -> data, valid, we, wdata
      add(mk(1, _LB,  GLSU, 5'd5, 5'd1, 32'd24), 0, 0, 0, 32'h80FF_0000, 32'hFFFF_FF80, 1, 0, 0);
      add(mk(1, _LBU, GLSU, 5'd6, 5'd1, 32'd24), 0, 0, 0, 32'h80FF_0000, 32'h0000_0080, 1, 0, 0);
      add(mk(1, _LB,  GLSU, 5'd7, 5'd1, 32'd8),  0, 0, 0, 32'h0000_7F00, 32'h0000_007F, 1, 0, 0);
      add(mk(1, _LH,  GLSU, 5'd8, 5'd1, 32'd16), 0, 0, 0, 32'h8001_0000, 32'hFFFF_8001, 1, 0, 0);
      add(mk(1, _LHU, GLSU, 5'd9, 5'd1, 32'd16), 0, 0, 0, 32'hBEEF_1234, 32'h0000_BEEF, 1, 0, 0);
      add(mk(1, _LW,  GLSU, 5'd10, 5'd1, 32'd0), 0, 0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0, 0);
      add(mk(1, _FLW, GLSU, 5'd11, 5'd1, 32'd0), 0, 0, 0, 32'h3F80_0000, 32'h3F80_0000, 1, 0, 0);
      add(mk(1, _NOP, GALU, 5'd12, 5'd0, 32'h0000_ABCD), 0, 0, 0, 0, 32'h0000_ABCD, 1, 0, 0);
      add(mk(0, _NOP, BRU,  5'd13, 5'd0, 32'h0000_0044), 0, 0, 0, 0, 32'h0000_0044, 0, 0, 0);
      add(mk(1, _NOP, GMUL, 5'd14, 5'd0, 32'h0000_0999), 32'h0000_0030, 0, 0, 0, 32'h0000_0030, 1, 0, 0);
      add(mk(1, _SW,  GLSU, 5'd0,  5'd2, 32'h0000_0100), 0, 0, 0, 0, 32'h0000_0100, 0, 0, 0);
      add(mk(1, _CSRRS,  CSR, 5'd3, 5'd0, 32'h300), 0, 32'h0,    32'h1800, 0, 32'h1800, 1, 0, 32'h1800);
      add(mk(1, _CSRRC,  CSR, 5'd3, 5'd1, 32'h300), 0, 32'h0800, 32'h1800, 0, 32'h1800, 1, 1, 32'h1000);
      add(mk(1, _CSRRW,  CSR, 5'd0, 5'd2, 32'h341), 0, 32'h55,   32'h1800, 0, 32'h1800, 1, 1, 32'h55);
      add(mk(1, _CSRRSI, CSR, 5'd4, 5'd3, 32'h305), 0, 32'h3,    32'h10,   0, 32'h10,   1, 1, 32'h13);
      add(mk(1, _CSRRCI, CSR, 5'd4, 5'd0, 32'h305), 0, 32'h0,    32'hFF,   0, 32'hFF,   1, 0, 32'hFF);

      foreach (vt[i]) begin
         drive(vt[i].u, vt[i].mul, vt[i].opnd, vt[i].rdata, vt[i].dword, 1'b0, 1'b0);
         #1;
         chk($sformatf("v%0d_csr_we", i),    32'(csr_we), 32'(vt[i].exp_we));
         chk($sformatf("v%0d_csr_wdata", i), csr_wdata,   vt[i].exp_wdata);
         chk($sformatf("v%0d_mem_stall", i), 32'(mstall), 0);
         if (vt[i].u.fu == CSR)
            chk($sformatf("v%0d_csr_addr", i), 32'(csr_addr), {20'd0, vt[i].u.result[11:0]});
         expect_wb(vt[i].exp_data, vt[i].exp_valid, vt[i].u.rd);
         tick();
      end

      // _LHU with D$ wait high for 3 cycles
      stalls = 0;
      for (int c = 0; c < 3; c++) begin
         drive(mk(1, _LHU, GLSU, 5'd9, 5'd1, 32'd16), 0, 0, 0, 32'h0, 1'b1, 1'b0);
         #1;
         if (mstall) stalls++;
         tick();
         chk($sformatf("miss_bubble%0d", c), 32'(wb_uop.valid), 0);
      end
      drive(mk(1, _LHU, GLSU, 5'd9, 5'd1, 32'd16), 0, 0, 0, 32'hBEEF_1234, 1'b0, 1'b0);
      #1;
      if (mstall) stalls++;
      chk("miss_stall_cycles", 32'(stalls), 3);
      expect_wb(32'h0000_BEEF, 1'b1, 5'd9);
      tick();

      // _LW hit under external stall, D$ output changes before release
      held = wb_data;
      for (int c = 0; c < 2; c++) begin
         drive(mk(1, _LW, GLSU, 5'd15, 5'd1, 32'd0), 0, 0, 0, 32'h1234_5678, 1'b0, 1'b1);
         #1;
         chk($sformatf("stall_csr_we%0d", c), 32'(csr_we), 0);
         tick();
         chk($sformatf("stall_hold%0d", c), wb_data, held);
      end
      drive(mk(1, _LW, GLSU, 5'd15, 5'd1, 32'd0), 0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      expect_wb(32'h1234_5678, 1'b1, 5'd15);
      tick();

      // Reset drops a filled load buffer
      drive(mk(1, _LW, GLSU, 5'd16, 5'd1, 32'd0), 0, 0, 0, 32'hAAAA_5555, 1'b0, 1'b1);
      tick();
      @(negedge clk); rst = 1'b1;
      tick();
      chk("bufrst_wb_uop", 32'(wb_uop != zu), 0);
      drive(mk(1, _LW, GLSU, 5'd17, 5'd1, 32'd0), 0, 0, 0, 32'h0F0F_0F0F, 1'b0, 1'b0);
      rst = 1'b0;
      expect_wb(32'h0F0F_0F0F, 1'b1, 5'd17);
      tick();

      // Reset while in WAIT
      drive(mk(1, _LW, GLSU, 5'd18, 5'd1, 32'd0), 0, 0, 0, 32'h0, 1'b1, 1'b0);
      tick();
      @(negedge clk); rst = 1'b1;
      tick();
      drive(zu, 0, 0, 0, 0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      chk("waitrst_mem_stall", 32'(mstall), 0);
      chk("waitrst_wb_uop", 32'(wb_uop != zu), 0);
      // A non-LSU op with wait still high must pass straight through from RUN
      drive(mk(1, _NOP, GALU, 5'd19, 5'd0, 32'h0000_0077), 0, 0, 0, 0, 1'b1, 1'b0);
      #1;
      chk("waitrst_run_nostall", 32'(mstall), 0);
      expect_wb(32'h0000_0077, 1'b1, 5'd19);
      tick();

      if (sbq.size() != 0) chk("sb_leftover", 32'(sbq.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
